// File: rtl/key_digit_buffer.sv
// key_digit_buffer: keypad BCD entry buffer with clear, backspace and serial digit sum on enter
module key_digit_buffer #(
  parameter int DIGITS = 6,
  parameter int CNT_W = 3,
  parameter int SUM_W = 8,
  parameter logic [3:0] KEY_CLR = 4'hA,
  parameter logic [3:0] KEY_BS = 4'hB,
  parameter logic [3:0] KEY_ENT = 4'hE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  press,
  input  logic [3:0]            scan_code,
  output logic [4*DIGITS-1:0]   key_buf_code,
  output logic [CNT_W-1:0]      digit_cnt,
  output logic                  full,
  output logic                  busy,
  output logic [SUM_W-1:0]      sum,
  output logic                  sum_valid,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;
  state_t r_state;
  logic r_press_d, r_sv, r_err;
  logic [4*DIGITS-1:0] r_buf;
  logic [CNT_W-1:0] r_cnt, r_idx;
  logic [SUM_W-1:0] r_acc, r_sum;
  logic w_ev, w_full;
  logic [3:0] w_nib;
  assign w_ev = press & ~r_press_d;
  assign w_full = r_cnt == CNT_W'(DIGITS);
  assign w_nib = r_buf[4*r_idx +: 4];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_press_d <= 1'b0;
      r_sv <= 1'b0;
      r_err <= 1'b0;
      r_buf <= '0;
      r_cnt <= '0;
      r_idx <= '0;
      r_acc <= '0;
      r_sum <= '0;
    end else begin
      r_press_d <= press;
      r_sv <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (w_ev) begin
          if (scan_code <= 4'd9) begin
            if (w_full) r_err <= 1'b1;
            else begin
              r_buf <= {r_buf[4*DIGITS-5:0], scan_code};
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else if (scan_code == KEY_BS) begin
            if (r_cnt != '0) begin
              r_buf <= {4'h0, r_buf[4*DIGITS-1:4]};
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end else if (scan_code == KEY_CLR) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_sum <= '0;
          end else if (scan_code == KEY_ENT) begin
            r_acc <= '0;
            r_idx <= '0;
            r_state <= (r_cnt != '0) ? SUM : DONE;
          end
        end
        SUM: begin
          r_acc <= r_acc + SUM_W'(w_nib);
          r_idx <= r_idx + CNT_W'(1);
          if (r_idx == r_cnt - CNT_W'(1)) r_state <= DONE;
        end
        DONE: begin
          r_sum <= r_acc;
          r_sv <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign key_buf_code = r_buf;
  assign digit_cnt = r_cnt;
  assign full = w_full;
  assign busy = r_state != IDLE;
  assign sum = r_sum;
  assign sum_valid = r_sv;
  assign err = r_err;
endmodule

// File: tb/tb_key_digit_buffer.sv
// tb_key_digit_buffer: random and directed keypad traffic checked against a queue-based model
module tb_key_digit_buffer;
  localparam int D = 6;
  logic clk = 0, rst = 1, press = 0;
  logic [3:0] scan_code = 0;
  logic [4*D-1:0] key_buf_code;
  logic [2:0] digit_cnt;
  logic full, busy, sum_valid, err;
  logic [7:0] sum;
  int checks = 0, errors = 0;
  int q[$];
  int busy_left, pend, m_sum;
  bit m_sv, m_err, pd;

  key_digit_buffer dut (.clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
    .key_buf_code(key_buf_code), .digit_cnt(digit_cnt), .full(full), .busy(busy),
    .sum(sum), .sum_valid(sum_valid), .err(err));

  always #5 clk = ~clk;

  function automatic logic [4*D-1:0] m_buf();
    logic [4*D-1:0] b = '0;
    foreach (q[i]) b[4*i +: 4] = 4'(q[i]);
    return b;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    busy_left = 0; pend = 0; m_sum = 0; m_sv = 0; m_err = 0; pd = 0;
  endtask

  // busy_left counts the edges until the sum lands: N summing edges plus the commit edge
  task automatic step();
    bit ev;
    ev = press && !pd;
    pd = press;
    m_sv = 0; m_err = 0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin m_sum = pend; m_sv = 1; end
    end else if (ev) begin
      if (scan_code <= 9) begin
        if (q.size() < D) q.push_front(int'(scan_code)); else m_err = 1;
      end else if (scan_code == 4'hB) begin
        if (q.size() > 0) void'(q.pop_front());
      end else if (scan_code == 4'hA) begin
        q.delete(); m_sum = 0;
      end else if (scan_code == 4'hE) begin
        pend = q.sum(); busy_left = q.size() + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else step();
    @(negedge clk);
  endtask

  task automatic key(input logic [3:0] c, input int hold);
    scan_code = c; press = 1;
    repeat (hold) tick();
    press = 0;
    tick();
  endtask

  always @(negedge clk) if (!rst) begin
    chk("buf", key_buf_code, m_buf());
    chk("cnt", digit_cnt, q.size());
    chk("full", full, q.size() == D);
    chk("busy", busy, busy_left > 0);
    chk("sum", sum, m_sum);
    chk("sum_valid", sum_valid, m_sv);
    chk("err", err, m_err);
  end

  initial begin
    int n;
    logic [3:0] c;
    model_reset();
    repeat (2) tick();
    chk("rst_buf", key_buf_code, 0);
    chk("rst_cnt", digit_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    tick();
    key(4'd3, 5);
    chk("t1_buf", key_buf_code, 24'h3);
    chk("t1_cnt", digit_cnt, 1);
    key(4'hA, 1);
    for (int d = 1; d <= 6; d++) key(4'(d), 1);
    chk("t2_buf", key_buf_code, 24'h123456);
    chk("t2_full", full, 1);
    scan_code = 4'd7; press = 1;
    tick();
    chk("t2_err", err, 1);
    press = 0;
    tick();
    chk("t2_err_pulse", err, 0);
    chk("t2_buf_kept", key_buf_code, 24'h123456);
    key(4'hA, 1);
    key(4'd7, 1); key(4'd8, 2); key(4'd9, 1);
    key(4'hB, 3);
    chk("t3_buf", key_buf_code, 24'h78);
    chk("t3_cnt", digit_cnt, 2);
    repeat (3) key(4'hB, 1);
    chk("t3_empty", key_buf_code, 0);
    chk("t3_err", err, 0);
    repeat (6) key(4'd9, 1);
    scan_code = 4'hE; press = 1;
    tick();
    press = 0;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    chk("t4_busy_cycles", n, 7);
    chk("t4_sum_valid", sum_valid, 1);
    chk("t4_sum", sum, 54);
    chk("t4_buf", key_buf_code, 24'h999999);
    key(4'hA, 1);
    key(4'd1, 1);
    key(4'hE, 1);
    key(4'd5, 1);
    chk("t5_ignored", key_buf_code, 24'h1);
    chk("t5_sum1", sum, 1);
    key(4'hA, 1);
    chk("t5_clr_sum", sum, 0);
    chk("t5_clr_cnt", digit_cnt, 0);
    scan_code = 4'hE; press = 1;
    tick();
    chk("t5_empty_busy", busy, 1);
    press = 0;
    tick();
    chk("t5_empty_sv", sum_valid, 1);
    chk("t5_empty_sum", sum, 0);
    key(4'd4, 1); key(4'd5, 1);
    scan_code = 4'hE; press = 1;
    tick();
    press = 0;
    tick();
    rst = 1;
    model_reset();
    #1;
    chk("t6_buf", key_buf_code, 0);
    chk("t6_busy", busy, 0);
    chk("t6_sv", sum_valid, 0);
    chk("t6_cnt", digit_cnt, 0);
    @(negedge clk);
    tick();
    rst = 0;
    tick();
    key(4'd2, 1);
    chk("t6_after", key_buf_code, 24'h2);
    repeat (600) begin
      n = $urandom_range(0, 15);
      c = (n < 10) ? 4'($urandom_range(0, 9)) : (n < 12) ? 4'hB : (n < 13) ? 4'hA :
          (n < 15) ? 4'hE : 4'($urandom_range(10, 15));
      scan_code = c; press = 1;
      repeat ($urandom_range(1, 4)) tick();
      press = 0;
      repeat ($urandom_range(0, 8)) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
